sys_tb_mem_ctrl: RTL and testbench

- Testbench-side initiator for the system block's testbench memory port (tbCTRL/WEN/REN/addr/store in, halt/load out).
- Preloads the program image into RAM and releases memory to the CPU.
- After the CPU asserts halt, takes RAM control back and streams out a full memory dump.
- Sits between the bench's image/dump handlers and the system top, on the same CLK that drives RAM.

---
 rtl/sys_tb_mem_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_sys_tb_mem_ctrl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sys_tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// sys_tb_mem_ctrl
//
// Testbench-side initiator for the system testbench memory port. It preloads
// a program image into RAM, hands the RAM over to the CPU, and waits for the
// CPU to halt. It then takes the RAM back and streams out a memory dump of
// WORDS 32-bit words, starting at byte address 0.
//
// Parameters:
//   LAT   - RAM access latency in CLK cycles; every access is held LAT+1 cycles
//   WORDS - number of 32-bit words in the dump
//   AW    - byte address width
//
// Ports:
//   CLK, nRST                     clock (shared with RAM), sync active-high reset
//   load_valid/ready/addr/data    image word stream into the block
//   load_done                     image complete, release memory to the CPU
//   halt                          CPU halted
//   tbCTRL, WEN, REN, addr, store testbench-side RAM control and write data
//   load                          RAM read data
//   run                           CPU owns memory (always ~tbCTRL)
//   dump_valid/ready/addr/data    memory dump stream out of the block
//   dump_done                     dump complete, sticky until reset
//
// Optional feature (macro SYS_TB_DUMP_SKIP_ZERO_EN):
//   when defined, words that read back as zero are not presented on the
//   dump stream; the block moves straight on to the next read (or to DONE).
// ---------------------------------------------------------------------------
module sys_tb_mem_ctrl #(
    parameter int LAT   = 3,
    parameter int WORDS = 1024,
    parameter int AW    = 32
) (
    input  logic          CLK,
    input  logic          nRST,
    input  logic          load_valid,
    output logic          load_ready,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    input  logic          load_done,
    input  logic          halt,
    output logic          tbCTRL,
    output logic          WEN,
    output logic          REN,
    output logic [AW-1:0] addr,
    output logic [31:0]   store,
    input  logic [31:0]   load,
    output logic          run,
    output logic          dump_valid,
    input  logic          dump_ready,
    output logic [AW-1:0] dump_addr,
    output logic [31:0]   dump_data,
    output logic          dump_done
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int HW = $clog2(LAT + 2);
    localparam logic [IW-1:0] LAST_IDX  = IW'(WORDS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LAT);

    typedef enum logic [2:0] {
        LOAD,
        WR,
        RUN,
        RD,
        OUT,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] holdCnt_q, holdCnt_d;
    logic [IW-1:0] index_q, index_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   store_q, store_d;
    logic [AW-1:0] dumpAddr_q, dumpAddr_d;
    logic [31:0]   dumpData_q, dumpData_d;

    logic [IW-1:0] nextIndex;
    logic [AW-1:0] nextAddr;
    logic          lastIdx;
    logic          holdLast;

    // Register stage for the FSM and all datapath registers. Reset is
    // synchronous, so an access in flight is simply abandoned at the edge.
    always_ff @(posedge CLK) begin
        if (nRST) begin
            state_q    <= LOAD;
            holdCnt_q  <= '0;
            index_q    <= '0;
            addr_q     <= '0;
            store_q    <= '0;
            dumpAddr_q <= '0;
            dumpData_q <= '0;
        end else begin
            state_q    <= state_d;
            holdCnt_q  <= holdCnt_d;
            index_q    <= index_d;
            addr_q     <= addr_d;
            store_q    <= store_d;
            dumpAddr_q <= dumpAddr_d;
            dumpData_q <= dumpData_d;
        end
    end

    // Word index helpers. The index is only advanced when it is not the last
    // one, so it never wraps.
    assign nextIndex = index_q + 1'b1;
    assign nextAddr  = AW'({nextIndex, 2'b00});
    assign lastIdx   = (index_q == LAST_IDX);
    assign holdLast  = (holdCnt_q == HOLD_LAST);

    // Next-state and per-state strobes. Enables are decoded from the state so
    // WEN and REN can never be high together. load_ready is held low while
    // reset is asserted so no image word is accepted during reset.
    always_comb begin
        state_d    = state_q;
        holdCnt_d  = holdCnt_q;
        index_d    = index_q;
        addr_d     = addr_q;
        store_d    = store_q;
        dumpAddr_d = dumpAddr_q;
        dumpData_d = dumpData_q;
        load_ready = 1'b0;
        WEN        = 1'b0;
        REN        = 1'b0;
        dump_valid = 1'b0;

        case (state_q)
            LOAD: begin
                load_ready = ~nRST;
                if (load_valid) begin
                    addr_d    = load_addr & ~AW'(3);
                    store_d   = load_data;
                    holdCnt_d = '0;
                    state_d   = WR;
                end else if (load_done) begin
                    state_d = RUN;
                end
            end
            WR: begin
                WEN = 1'b1;
                if (holdLast) begin
                    holdCnt_d = '0;
                    state_d   = LOAD;
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            RUN: begin
                if (halt) begin
                    index_d   = '0;
                    addr_d    = '0;
                    holdCnt_d = '0;
                    state_d   = RD;
                end
            end
            RD: begin
                REN = 1'b1;
                if (holdLast) begin
                    holdCnt_d = '0;
`ifdef SYS_TB_DUMP_SKIP_ZERO_EN
                    if (load == 32'h0) begin
                        if (lastIdx) begin
                            state_d = DONE;
                        end else begin
                            index_d = nextIndex;
                            addr_d  = nextAddr;
                            state_d = RD;
                        end
                    end else begin
                        dumpData_d = load;
                        dumpAddr_d = addr_q;
                        state_d    = OUT;
                    end
`else
                    dumpData_d = load;
                    dumpAddr_d = addr_q;
                    state_d    = OUT;
`endif
                end else begin
                    holdCnt_d = holdCnt_q + 1'b1;
                end
            end
            OUT: begin
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (lastIdx) begin
                        state_d = DONE;
                    end else begin
                        index_d = nextIndex;
                        addr_d  = nextAddr;
                        state_d = RD;
                    end
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // The CPU owns memory only in RUN; everywhere else the testbench does.
    assign tbCTRL    = (state_q != RUN);
    assign run       = (state_q == RUN);
    assign dump_done = (state_q == DONE);
    assign addr      = addr_q;
    assign store     = store_q;
    assign dump_addr = dumpAddr_q;
    assign dump_data = dumpData_q;

endmodule

// File: tb/tb_sys_tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sys_tb_mem_ctrl
//
// Bench for sys_tb_mem_ctrl with LAT=3, WORDS=4. A small RAM model answers
// reads only on the last cycle of each LAT+1 access. Expected RAM writes and
// dump words are queued when stimulus is driven and checked by monitors when
// the DUT produces them. Honours SYS_TB_DUMP_SKIP_ZERO_EN for expectations.
// ---------------------------------------------------------------------------
module tb_sys_tb_mem_ctrl;

    localparam int LAT   = 3;
    localparam int WORDS = 4;
    localparam int AW    = 32;

    logic          CLK = 1'b0;
    logic          nRST;
    logic          load_valid;
    logic          load_ready;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic          load_done;
    logic          halt;
    logic          tbCTRL;
    logic          WEN;
    logic          REN;
    logic [AW-1:0] addr;
    logic [31:0]   store;
    logic [31:0]   load;
    logic          run;
    logic          dump_valid;
    logic          dump_ready;
    logic [AW-1:0] dump_addr;
    logic [31:0]   dump_data;
    logic          dump_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] ramMem [16];
    logic [31:0] refMem [16];
    int          ramRdRun;
    int          ramWrRun;

    logic [63:0] wrQ [$];
    logic [63:0] dumpQ [$];
    int          wenCnt = 0;
    logic [31:0] wAddr;
    logic [31:0] wData;
    int          dumpCount = 0;
    int          expDumpCount = 0;

    always #5 CLK = ~CLK;

    sys_tb_mem_ctrl #(
        .LAT   (LAT),
        .WORDS (WORDS),
        .AW    (AW)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .load_done  (load_done),
        .halt       (halt),
        .tbCTRL     (tbCTRL),
        .WEN        (WEN),
        .REN        (REN),
        .addr       (addr),
        .store      (store),
        .load       (load),
        .run        (run),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

    // RAM model: read data is only meaningful on the final cycle of an
    // access; any earlier capture by the DUT sees a poison value instead.
    assign load = (REN && ramRdRun == LAT) ? ramMem[addr[5:2]] : 32'hBAD0_BAD0;

    // Access-length tracking for the RAM model; a write lands on the last
    // cycle of its hold window.
    always @(posedge CLK) begin
        if (nRST) begin
            ramRdRun <= 0;
            ramWrRun <= 0;
        end else begin
            if (REN) ramRdRun <= (ramRdRun == LAT) ? 0 : ramRdRun + 1;
            else     ramRdRun <= 0;
            if (WEN) begin
                if (ramWrRun == LAT) begin
                    ramMem[addr[5:2]] = store;
                    ramWrRun <= 0;
                end else begin
                    ramWrRun <= ramWrRun + 1;
                end
            end else begin
                ramWrRun <= 0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Monitor on the falling edge: measures each WEN pulse and compares it
    // against the queued write, and scores every dump handshake.
    always @(negedge CLK) begin
        logic [63:0] exp;
        if (nRST) begin
            wenCnt = 0;
        end else begin
            if (WEN || REN) checkOutput("wenRenExcl", 64'(WEN && REN), 64'(0));
            if (WEN) begin
                if (wenCnt == 0) begin
                    wAddr = addr;
                    wData = store;
                end else begin
                    checkOutput("wrAddrStable", 64'(addr), 64'(wAddr));
                    checkOutput("wrDataStable", 64'(store), 64'(wData));
                end
                wenCnt++;
            end else if (wenCnt != 0) begin
                if (wrQ.size() == 0) begin
                    checkOutput("wrUnexpected", 64'(wenCnt), 64'(0));
                end else begin
                    exp = wrQ.pop_front();
                    checkOutput("wrAddr", 64'(wAddr), 64'(exp[63:32]));
                    checkOutput("wrData", 64'(wData), 64'(exp[31:0]));
                    checkOutput("wenWidth", 64'(wenCnt), 64'(LAT + 1));
                end
                wenCnt = 0;
            end
            if (dump_valid && dump_ready) begin
                dumpCount++;
                if (dumpQ.size() == 0) begin
                    checkOutput("dumpUnexpected", 64'(dump_addr), 64'hFFFF_FFFF);
                end else begin
                    exp = dumpQ.pop_front();
                    checkOutput("dumpAddr", 64'(dump_addr), 64'(exp[63:32]));
                    checkOutput("dumpData", 64'(dump_data), 64'(exp[31:0]));
                end
            end
        end
    end

    // Drives one image word, waits for it to be accepted and queues the
    // write the RAM should see.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic withDone);
        int cnt;
        load_addr  = a;
        load_data  = d;
        load_valid = 1'b1;
        if (withDone) load_done = 1'b1;
        cnt = 0;
        while (load_ready !== 1'b1 && cnt < 50) begin
            tick();
            cnt++;
        end
        checkOutput("loadReadyWait", 64'(load_ready), 64'(1));
        wrQ.push_back({a & 32'hFFFF_FFFC, d});
        refMem[a[5:2]] = d;
        tick();
        load_valid = 1'b0;
        checkOutput("wenAfterAccept", 64'(WEN), 64'(1));
        if (withDone) checkOutput("runLowDuringWr", 64'(run), 64'(0));
    endtask

    task automatic pushDumpExpectations();
        dumpCount    = 0;
        expDumpCount = 0;
        for (int i = 0; i < WORDS; i++) begin
`ifdef SYS_TB_DUMP_SKIP_ZERO_EN
            if (refMem[i] != 32'h0) begin
`else
            begin
`endif
                dumpQ.push_back({32'(i * 4), refMem[i]});
                expDumpCount++;
            end
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, ".tbCTRL"}, 64'(tbCTRL), 64'(1));
        checkOutput({tag, ".run"}, 64'(run), 64'(0));
        checkOutput({tag, ".WEN"}, 64'(WEN), 64'(0));
        checkOutput({tag, ".REN"}, 64'(REN), 64'(0));
        checkOutput({tag, ".addr"}, 64'(addr), 64'(0));
        checkOutput({tag, ".store"}, 64'(store), 64'(0));
        checkOutput({tag, ".loadReady"}, 64'(load_ready), 64'(0));
        checkOutput({tag, ".dumpValid"}, 64'(dump_valid), 64'(0));
        checkOutput({tag, ".dumpAddr"}, 64'(dump_addr), 64'(0));
        checkOutput({tag, ".dumpData"}, 64'(dump_data), 64'(0));
        checkOutput({tag, ".dumpDone"}, 64'(dump_done), 64'(0));
    endtask

    task automatic waitRun();
        int cnt;
        cnt = 0;
        while (run !== 1'b1 && cnt < 100) begin
            tick();
            cnt++;
        end
        checkOutput("runHigh", 64'(run), 64'(1));
        checkOutput("tbCtrlLowInRun", 64'(tbCTRL), 64'(0));
    endtask

    task automatic waitDone();
        int cnt;
        cnt = 0;
        while (dump_done !== 1'b1 && cnt < 300) begin
            tick();
            cnt++;
        end
        checkOutput("dumpDone", 64'(dump_done), 64'(1));
        checkOutput("tbCtrlInDone", 64'(tbCTRL), 64'(1));
        checkOutput("runLowInDone", 64'(run), 64'(0));
        checkOutput("dumpQEmpty", 64'(dumpQ.size()), 64'(0));
        checkOutput("dumpCount", 64'(dumpCount), 64'(expDumpCount));
    endtask

    // Main sequence: reset, image load, dump with a stall, reset out of DONE,
    // reset in the middle of a read, and a final load/dump with zero words.
    initial begin
        int cnt;
        logic [31:0] sAddr;
        logic [31:0] sData;

        nRST       = 1'b1;
        load_valid = 1'b0;
        load_addr  = '0;
        load_data  = '0;
        load_done  = 1'b0;
        halt       = 1'b0;
        dump_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ramMem[i] = 32'hA5A5_0000 | 32'(i);
            refMem[i] = 32'hA5A5_0000 | 32'(i);
        end

        tick();
        tick();
        tick();
        checkResetValues("rst0");
        nRST = 1'b0;
        tick();
        checkOutput("loadReadyAfterRst", 64'(load_ready), 64'(1));

        applyStimulus(32'h0, 32'hDEAD_BEEF, 1'b0);
        applyStimulus(32'h4, 32'h1234_5678, 1'b0);
        applyStimulus(32'h6, 32'hCAFE_F00D, 1'b0);
        applyStimulus(32'h10, 32'h0BAD_F00D, 1'b1);
        waitRun();
        load_done = 1'b0;
        checkOutput("wrQDrained", 64'(wrQ.size()), 64'(0));

        tick();
        tick();
        checkOutput("runHeld", 64'(run), 64'(1));
        pushDumpExpectations();
        halt = 1'b1;
        for (int w = 0; w < 4; w++) begin
            cnt = 0;
            while (dump_valid !== 1'b1 && cnt < 50) begin
                tick();
                cnt++;
            end
            checkOutput("dumpValidWait", 64'(dump_valid), 64'(1));
            if (w == 2) begin
                sAddr = dump_addr;
                sData = dump_data;
                for (int k = 0; k < 10; k++) begin
                    checkOutput("stallValid", 64'(dump_valid), 64'(1));
                    checkOutput("stallAddr", 64'(dump_addr), 64'(sAddr));
                    checkOutput("stallData", 64'(dump_data), 64'(sData));
                    checkOutput("stallNoRen", 64'(REN), 64'(0));
                    tick();
                end
            end
            dump_ready = 1'b1;
            tick();
            dump_ready = 1'b0;
            checkOutput("validDrop", 64'(dump_valid), 64'(0));
        end
        waitDone();
        tick();
        tick();
        checkOutput("doneNoRen", 64'(REN), 64'(0));
        checkOutput("doneSticky", 64'(dump_done), 64'(1));

        nRST = 1'b1;
        tick();
        checkResetValues("rstDone");
        halt = 1'b0;
        nRST = 1'b0;
        tick();

        load_done = 1'b1;
        waitRun();
        load_done = 1'b0;
        halt = 1'b1;
        cnt = 0;
        while (REN !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        checkOutput("renMidRd", 64'(REN), 64'(1));
        tick();
        nRST = 1'b1;
        tick();
        checkResetValues("rstMidRd");
        dumpQ.delete();
        halt = 1'b0;
        nRST = 1'b0;
        tick();
        checkOutput("loadReadyRestart", 64'(load_ready), 64'(1));

        applyStimulus(32'h0, 32'h5, 1'b0);
        applyStimulus(32'h4, 32'h0, 1'b0);
        applyStimulus(32'h8, 32'h0, 1'b0);
        applyStimulus(32'hC, 32'h7, 1'b0);
        load_done = 1'b1;
        waitRun();
        load_done = 1'b0;
        pushDumpExpectations();
        dump_ready = 1'b1;
        halt = 1'b1;
        waitDone();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
